// File: rtl/sevenseg_scan_if.sv
// sevenseg_scan_if: load handshake between the processor-side output
// register (master) and the seven-segment scanner (slave).
//   value      : packed digits, digit i at [i*DIG_BITS +: DIG_BITS]
//   blank      : per-digit blank request, captured together with value
//   load       : request to capture value/blank
//   load_ready : high when a load will be accepted
interface sevenseg_scan_if #(
   parameter int NUM_DIGITS = 4,
   parameter int DIG_BITS   = 4
);
   logic [NUM_DIGITS*DIG_BITS-1:0] value;
   logic [NUM_DIGITS-1:0]          blank;
   logic                           load;
   logic                           load_ready;

   modport master (output value, output blank, output load, input load_ready);
   modport slave  (input value, input blank, input load, output load_ready);
endinterface

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed multi-digit seven-segment driver for a
// common-anode display. A double-buffered display value is scanned one digit
// per SCAN_DIV clocks; new data is only committed at frame boundaries.
//
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sevenseg_scan_if.slave (value, blank, load, load_ready)
//   seg   : segments {g,f,e,d,c,b,a}, active low, registered
//   an    : digit enables, active low, one-cold, registered
//
// Build option: define SEVENSEG_LZB_EN to blank leading zero digits
// (digit 0 always shows); otherwise only the blank input blanks digits.
module sevenseg_scan #(
   parameter int NUM_DIGITS = 4,
   parameter int DIG_BITS   = 4,
   parameter int SCAN_DIV   = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sevenseg_scan_if.slave        bus,
   output logic [6:0]            seg,
   output logic [NUM_DIGITS-1:0] an
);

   localparam int VAL_W = NUM_DIGITS * DIG_BITS;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(SCAN_DIV);

   generate
      if (DIG_BITS != 3 && DIG_BITS != 4) begin : g_bad_dig_bits
         $error("sevenseg_scan: DIG_BITS must be 3 or 4");
      end
      if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
         $error("sevenseg_scan: NUM_DIGITS must be 1..8");
      end
      if (SCAN_DIV < 2) begin : g_bad_scan_div
         $error("sevenseg_scan: SCAN_DIV must be at least 2");
      end
   endgenerate

   function automatic logic [6:0] f_glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'h0:    g = 7'b1000000;
         4'h1:    g = 7'b1111001;
         4'h2:    g = 7'b0100100;
         4'h3:    g = 7'b0110000;
         4'h4:    g = 7'b0011001;
         4'h5:    g = 7'b0010010;
         4'h6:    g = 7'b0000010;
         4'h7:    g = 7'b1011000;
         4'h8:    g = 7'b0000000;
         4'h9:    g = 7'b0010000;
         4'hA:    g = 7'b0001000;
         4'hB:    g = 7'b0000011;
         4'hC:    g = 7'b1000110;
         4'hD:    g = 7'b0100001;
         4'hE:    g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   logic [CNT_W-1:0]      r_cnt;
   logic [IDX_W-1:0]      r_idx;
   logic [VAL_W-1:0]      r_pend_val;
   logic [NUM_DIGITS-1:0] r_pend_blank;
   logic                  r_pend_v;
   logic [VAL_W-1:0]      r_disp_val;
   logic [NUM_DIGITS-1:0] r_disp_blank;
   logic [6:0]            r_seg;
   logic [NUM_DIGITS-1:0] r_an;

   logic                  w_tick;
   logic                  w_wrap;
   logic                  w_commit;
   logic                  w_accept;
   logic [3:0]            w_digit;
   logic [NUM_DIGITS-1:0] w_lzb;
   logic [6:0]            w_seg;
   logic [NUM_DIGITS-1:0] w_an;

   assign w_tick   = (r_cnt == CNT_W'(SCAN_DIV - 1));
   assign w_wrap   = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
   assign w_commit = w_wrap && r_pend_v;
   // Refused while pending is full, including the commit edge itself.
   assign w_accept = bus.load && !r_pend_v;

   assign bus.load_ready = !r_pend_v;

`ifdef SEVENSEG_LZB_EN
   // Walk from the top digit down; a digit is a leading zero until the
   // first non-zero digit is seen. Digit 0 is excluded from the walk.
   always_comb begin
      logic seen;
      seen  = 1'b0;
      w_lzb = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (r_disp_val[i*DIG_BITS +: DIG_BITS] != '0) begin
            seen = 1'b1;
         end
         w_lzb[i] = !seen;
      end
   end
`else
   assign w_lzb = '0;
`endif

   assign w_digit = 4'(r_disp_val[r_idx*DIG_BITS +: DIG_BITS]);
   assign w_seg   = (r_disp_blank[r_idx] || w_lzb[r_idx]) ? 7'b1111111 : f_glyph(w_digit);
   assign w_an    = ~(NUM_DIGITS'(1) << r_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_idx        <= '0;
         r_pend_val   <= '0;
         r_pend_blank <= '0;
         r_pend_v     <= 1'b0;
         r_disp_val   <= '0;
         r_disp_blank <= '0;
         r_seg        <= 7'b1111111;
         r_an         <= '1;
      end else begin
         r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
         if (w_tick) begin
            r_idx <= w_wrap ? '0 : r_idx + 1'b1;
         end
         if (w_commit) begin
            r_disp_val   <= r_pend_val;
            r_disp_blank <= r_pend_blank;
            r_pend_v     <= 1'b0;
         end else if (w_accept) begin
            r_pend_val   <= bus.value;
            r_pend_blank <= bus.blank;
            r_pend_v     <= 1'b1;
         end
         // Outputs follow idx/disp with one cycle of latency.
         r_seg <= w_seg;
         r_an  <= w_an;
      end
   end

   assign seg = r_seg;
   assign an  = r_an;

endmodule

// File: tb/tb_sevenseg_scan.sv
module tb_sevenseg_scan;

   localparam int N = 4;
   localparam int S = 4;

   localparam logic [6:0] GLY [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] seg;
   logic [3:0] an;
   logic [6:0] seg_o;
   logic [1:0] an_o;

   sevenseg_scan_if #(.NUM_DIGITS(4), .DIG_BITS(4)) bus ();
   sevenseg_scan_if #(.NUM_DIGITS(2), .DIG_BITS(3)) bus_o ();

   sevenseg_scan #(.NUM_DIGITS(4), .DIG_BITS(4), .SCAN_DIV(S)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .seg(seg), .an(an));

   sevenseg_scan #(.NUM_DIGITS(2), .DIG_BITS(3), .SCAN_DIV(3)) dut_oct (
      .clk(clk), .rst_n(rst_n), .bus(bus_o), .seg(seg_o), .an(an_o));

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Reference model: edges since reset release plus the two buffers.
   int          e;
   logic [15:0] m_disp, m_pend;
   logic [3:0]  m_db, m_pb;
   bit          m_pv;

   typedef struct packed {
      logic [15:0]     value;
      logic [3:0]      blank;
      logic [3:0][6:0] segs;
   } vec_t;
   vec_t vec [5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (time %0t)", nm, act, exp, $time);
   endtask

   task automatic model_reset();
      e = 0; m_disp = '0; m_pend = '0; m_db = '0; m_pb = '0; m_pv = 1'b0;
   endtask

   // One clock edge: predict outputs from pre-edge state, update the model
   // from the rules, then compare slightly after the edge.
   task automatic step();
      int         di;
      logic [3:0] dg;
      logic       bl;
      logic [6:0] es;
      logic [3:0] ea;
      bit         acc, com;
      @(posedge clk);
      e++;
      di = ((e - 1) / S) % N;
      dg = 4'(m_disp >> (4 * di));
      bl = m_db[di];
`ifdef SEVENSEG_LZB_EN
      if (di != 0 && (m_disp >> (4 * di)) == 16'h0) bl = 1'b1;
`endif
      es = bl ? 7'h7F : GLY[dg];
      ea = 4'hF;
      ea[di] = 1'b0;
      acc = bus.load && !m_pv;
      com = (e % (N * S) == 0) && m_pv;
      if (com) begin
         m_disp = m_pend; m_db = m_pb; m_pv = 1'b0;
      end else if (acc) begin
         m_pend = bus.value; m_pb = bus.blank; m_pv = 1'b1;
      end
      #1;
      chk("seg", 32'(seg), 32'(es));
      chk("an", 32'(an), 32'(ea));
      chk("load_ready", 32'(bus.load_ready), 32'(!m_pv));
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!bus.load_ready && k < 100) begin
         step();
         k++;
      end
      chk("ready_timeout", 32'(bus.load_ready), 32'd1);
   endtask

   initial begin
      logic [3:0][6:0] cap;
      logic [1:0][6:0] cap_o;

      vec[0] = '{16'h12AF, 4'b0000, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}};
`ifdef SEVENSEG_LZB_EN
      vec[1] = '{16'h0007, 4'b1000, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1011000}};
      vec[3] = '{16'h0000, 4'b0000, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
      vec[4] = '{16'h0B96, 4'b0001, {7'b1111111, 7'b0000011, 7'b0010000, 7'b1111111}};
`else
      vec[1] = '{16'h0007, 4'b1000, {7'b1111111, 7'b1000000, 7'b1000000, 7'b1011000}};
      vec[3] = '{16'h0000, 4'b0000, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
      vec[4] = '{16'h0B96, 4'b0001, {7'b1000000, 7'b0000011, 7'b0010000, 7'b1111111}};
`endif
      vec[2] = '{16'h3C0D, 4'b0010, {7'b0110000, 7'b1000110, 7'b1111111, 7'b0100001}};

      rst_n = 1'b0;
      bus.value = '0; bus.blank = '0; bus.load = 1'b0;
      bus_o.value = '0; bus_o.blank = '0; bus_o.load = 1'b0;
      model_reset();
      #12;
      chk("reset_seg", 32'(seg), 32'h7F);
      chk("reset_an", 32'(an), 32'hF);
      chk("reset_ready", 32'(bus.load_ready), 32'd1);
      chk("reset_an_oct", 32'(an_o), 32'h3);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle scanning for two frames.
      for (int c = 0; c < 2 * N * S; c++) step();

      // Table-driven loads, each followed by a refused second load.
      for (int v = 0; v < 5; v++) begin
         wait_ready();
         bus.value = vec[v].value; bus.blank = vec[v].blank; bus.load = 1'b1;
         step();
         bus.load = 1'b0;
         chk("accept_drops_ready", 32'(bus.load_ready), 32'd0);
         bus.value = 16'hFFFF; bus.blank = 4'h0; bus.load = 1'b1;
         step();
         bus.load = 1'b0;
         wait_ready();
         cap = 'x;
         for (int c = 0; c < N * S; c++) begin
            step();
            for (int d = 0; d < N; d++)
               if (an == ~(4'b0001 << d)) cap[d] = seg;
         end
         for (int d = 0; d < N; d++)
            chk($sformatf("vec%0d_dig%0d", v, d), 32'(cap[d]), 32'(vec[v].segs[d]));
      end

      // Randomised traffic against the model.
      for (int c = 0; c < 400; c++) begin
         bus.load  = ($urandom_range(0, 5) == 0);
         bus.value = 16'($urandom) >> $urandom_range(0, 15);
         bus.blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         step();
      end
      bus.load = 1'b0;

      // Asynchronous reset mid-frame with pending data held.
      wait_ready();
      step();
      bus.value = 16'h5678; bus.blank = 4'h0; bus.load = 1'b1;
      step();
      bus.load = 1'b0;
      chk("pend_before_reset", 32'(bus.load_ready), 32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_seg", 32'(seg), 32'h7F);
      chk("async_an", 32'(an), 32'hF);
      chk("async_ready", 32'(bus.load_ready), 32'd1);
      chk("async_an_oct", 32'(an_o), 32'h3);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3 * N * S; c++) step();

      // Octal build, two digits, value 75 octal.
      bus_o.value = 6'o75; bus_o.load = 1'b1;
      step();
      bus_o.load = 1'b0;
      chk("oct_accept", 32'(bus_o.load_ready), 32'd0);
      cap_o = 'x;
      for (int c = 0; c < 30; c++) begin
         step();
         if (c >= 16) begin
            if (an_o == 2'b10) cap_o[0] = seg_o;
            if (an_o == 2'b01) cap_o[1] = seg_o;
         end
      end
      chk("oct_ready_back", 32'(bus_o.load_ready), 32'd1);
      chk("oct_dig0", 32'(cap_o[0]), 32'(7'b0010010));
      chk("oct_dig1", 32'(cap_o[1]), 32'(7'b1011000));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
